// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and the iteration count.
package muldiv_hilo_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// One bit per cycle over 32 CALC cycles, then a FIX cycle applies signs.
module muldiv_hilo
    import muldiv_hilo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  wr_hi,
    input  logic                  wr_lo,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;

    mdu_state_e state, state_next;
    mdu_op_e    op_q;
    mdu_op_e    op_in;

    logic [4:0]   count;
    logic [W-1:0] mag_a, mag_b;
    logic         neg_res, neg_rem, div_zero;
    logic [W-1:0] work_hi, work_lo;
    logic [W-1:0] hi_q, lo_q;
    logic         done_q;

    logic         signed_in, a_neg, b_neg, div_in;
    logic [W-1:0] mag_a_in, mag_b_in;
    logic         op_is_div;
    logic [W:0]   mul_sum, div_shift, div_diff;
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0] quot_fix, rem_fix, div0_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == 5'(ITER_COUNT - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand conditioning at launch: magnitudes for signed ops, raw otherwise.
    always_comb begin
        op_in     = mdu_op_e'(op);
        signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
        div_in    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
        a_neg     = signed_in & a[W-1];
        b_neg     = signed_in & b[W-1];
        mag_a_in  = a_neg ? (~a + 1'b1) : a;
        mag_b_in  = b_neg ? (~b + 1'b1) : b;
    end

    // Per-iteration arithmetic and the sign fix-up applied in FIX.
    always_comb begin
        op_is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
        div_shift = {work_hi, work_lo[W-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        prod      = {work_hi, work_lo};
        prod_fix  = neg_res ? (~prod + 1'b1) : prod;
        quot_fix  = neg_res ? (~work_lo + 1'b1) : work_lo;
        rem_fix   = neg_rem ? (~work_hi + 1'b1) : work_hi;
        div0_hi   = neg_rem ? (~mag_a + 1'b1) : mag_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= MDU_MULT;
            count    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            work_hi  <= '0;
            work_lo  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    count <= '0;
                    if (wr_hi) hi_q <= wr_data;
                    if (wr_lo) lo_q <= wr_data;
                    if (start) begin
                        op_q     <= op_in;
                        mag_a    <= mag_a_in;
                        mag_b    <= mag_b_in;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= div_in && (b == '0);
                        work_hi  <= '0;
                        work_lo  <= div_in ? mag_a_in : mag_b_in;
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    // Restoring divide keeps the difference only when non-negative.
                    if (op_is_div) begin
                        work_hi <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
                        work_lo <= {work_lo[W-2:0], ~div_diff[W]};
                    end else begin
                        work_hi <= mul_sum[W:1];
                        work_lo <= {mul_sum[0], work_lo[W-1:1]};
                    end
                end
                FIX: begin
                    if (div_zero) begin
                        hi_q <= div0_hi;
                        lo_q <= '1;
                    end else if (op_is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
